// File: rtl/wasm_opstk_pkg.sv
// wasm_opstk_pkg: shared error codes, local-op encodings and FSM states for the operand stack.
package wasm_opstk_pkg;
   localparam logic [2:0] ERR_NONE        = 3'd0;
   localparam logic [2:0] ERR_UNDERFLOW   = 3'd1;
   localparam logic [2:0] ERR_OVERFLOW    = 3'd2;
   localparam logic [2:0] ERR_FRAME_OVF   = 3'd3;
   localparam logic [2:0] ERR_FRAME_UNF   = 3'd4;
   localparam logic [2:0] ERR_LOCAL_RANGE = 3'd5;
   localparam logic [2:0] ERR_ILLEGAL     = 3'd6;
   localparam logic [1:0] LOP_NONE = 2'd0;
   localparam logic [1:0] LOP_GET  = 2'd1;
   localparam logic [1:0] LOP_SET  = 2'd2;
   localparam logic [1:0] LOP_TEE  = 2'd3;
   typedef enum logic {ST_IDLE, ST_ZFILL} st_t;
endpackage

// File: rtl/wasm_frame_lifo.sv
// wasm_frame_lifo: FDEPTH-entry LIFO holding the caller's {base, size} for each open frame.
module wasm_frame_lifo #(
   parameter int FDEPTH = 16,
   parameter int DW = 14,
   localparam int LW = $clog2(FDEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);
   localparam int AW = $clog2(FDEPTH);
   logic [DW-1:0] mem [FDEPTH];
   logic [LW-1:0] cnt;
   assign level = cnt;
   assign full = cnt == LW'(FDEPTH);
   assign empty = cnt == '0;
   assign dout = mem[AW'(cnt - 1'b1)];
   always_ff @(posedge clk)
      if (push) mem[AW'(cnt)] <= din;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (push) cnt <= cnt + 1'b1;
      else if (pop) cnt <= cnt - 1'b1;
endmodule

// File: rtl/wasm_operand_stack_v2.sv
// wasm_operand_stack_v2: operand/local stack with frame LIFO, zero-filled call locals and bounds-checked ops.
// Defining WASM_OPSTK_HWM_EN adds the max_top high-water-mark output.
module wasm_operand_stack_v2
   import wasm_opstk_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64,
   parameter int FDEPTH = 16,
   parameter int WIN = 3,
   parameter int POP_W = 4,
   parameter int LOC_W = 8,
   localparam int PTR_W = $clog2(DEPTH) + 1,
   localparam int FL_W = $clog2(FDEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               op_vld,
   output logic               op_rdy,
   input  logic [POP_W-1:0]   pop_num,
   input  logic               push_en,
   input  logic [WIDTH-1:0]   push_data,
   input  logic               call_en,
   input  logic [LOC_W-1:0]   call_nparams,
   input  logic [LOC_W-1:0]   call_nlocals,
   input  logic               ret_en,
   input  logic               ret_num,
   input  logic [1:0]         local_op,
   input  logic [LOC_W-1:0]   local_idx,
   output logic [WIN*WIDTH-1:0] win_data,
   output logic [WIDTH-1:0]   local_data,
   output logic [PTR_W-1:0]   top_ptr,
   output logic [PTR_W-1:0]   frame_base,
   output logic [FL_W-1:0]    frame_level,
   output logic               err_vld,
   output logic [2:0]         err_code,
   output logic               err_sticky
`ifdef WASM_OPSTK_HWM_EN
   ,
   output logic [PTR_W-1:0]   max_top
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = PTR_W + LOC_W + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] top, base, fsize, top_nx, f_base, f_size;
   logic [2*PTR_W-1:0] f_dout;
   logic [LOC_W-1:0] zcnt;
   st_t st;
   logic [2:0] err;
   logic acc, ok, is_plain, is_local, we, f_full, f_empty;
   logic [AW-1:0] wa;
   logic [WIDTH-1:0] wd, tos;
   logic [EW-1:0] t, b, avail, la;
   assign is_plain = pop_num != '0 || push_en;
   assign is_local = local_op != LOP_NONE;
   assign t = EW'(top);
   assign b = EW'(base);
   assign avail = t - b;
   assign la = b + EW'(local_idx);
   assign tos = mem[AW'(top - 1'b1)];
   assign local_data = la < EW'(DEPTH) ? mem[AW'(la)] : '0;
   assign acc = op_vld && op_rdy;
   assign ok = acc && err == ERR_NONE;
   assign top_ptr = top;
   assign frame_base = base;
   assign {f_base, f_size} = f_dout;
   for (genvar k = 0; k < WIN; k++)
      assign win_data[k*WIDTH +: WIDTH] = top > PTR_W'(k) ? mem[AW'(top - PTR_W'(k + 1))] : '0;
   // All bounds are evaluated in a widened domain so no subtraction or sum can wrap.
   always_comb begin
      err = ERR_NONE;
      if (3'(is_plain) + 3'(call_en) + 3'(ret_en) + 3'(is_local) > 3'd1) err = ERR_ILLEGAL;
      else if (call_en) err = f_full ? ERR_FRAME_OVF : EW'(call_nparams) > avail ? ERR_UNDERFLOW :
         t + EW'(call_nlocals) > EW'(DEPTH) ? ERR_OVERFLOW : ERR_NONE;
      else if (ret_en) err = f_empty ? ERR_FRAME_UNF : (ret_num && t == b) ? ERR_UNDERFLOW : ERR_NONE;
      else if (is_local) err = EW'(local_idx) >= EW'(fsize) ? ERR_LOCAL_RANGE :
         local_op == LOP_GET ? (t >= EW'(DEPTH) ? ERR_OVERFLOW : ERR_NONE) : t == b ? ERR_UNDERFLOW : ERR_NONE;
      else err = EW'(pop_num) > avail ? ERR_UNDERFLOW :
         t - EW'(pop_num) + EW'(push_en) > EW'(DEPTH) ? ERR_OVERFLOW : ERR_NONE;
   end
   assign top_nx = st == ST_ZFILL ? top + 1'b1 : !ok ? top : ret_en ? base + PTR_W'(ret_num) :
      call_en ? top : local_op == LOP_GET ? top + 1'b1 : local_op == LOP_SET ? top - 1'b1 :
      local_op == LOP_TEE ? top : top - PTR_W'(pop_num) + PTR_W'(push_en);
   always_comb begin
      we = 1'b0;
      wa = AW'(top);
      wd = '0;
      if (st == ST_ZFILL) we = 1'b1;
      else if (ok && ret_en) begin we = ret_num; wa = AW'(base); wd = tos; end
      else if (ok && local_op == LOP_GET) begin we = 1'b1; wd = local_data; end
      else if (ok && is_local) begin we = 1'b1; wa = AW'(la); wd = tos; end
      else if (ok && !call_en) begin we = push_en; wa = AW'(top - PTR_W'(pop_num)); wd = push_data; end
   end
   always_ff @(posedge clk)
      if (we) mem[wa] <= wd;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st <= ST_IDLE;
         op_rdy <= 1'b1;
         top <= '0;
         base <= '0;
         fsize <= '0;
         zcnt <= '0;
         err_vld <= 1'b0;
         err_code <= ERR_NONE;
         err_sticky <= 1'b0;
      end else begin
         top <= top_nx;
         err_vld <= acc && err != ERR_NONE;
         if (acc && err != ERR_NONE) begin err_code <= err; err_sticky <= 1'b1; end
         if (st == ST_ZFILL) begin
            zcnt <= zcnt - 1'b1;
            if (zcnt == LOC_W'(1)) begin st <= ST_IDLE; op_rdy <= 1'b1; end
         end else if (ok && call_en) begin
            base <= top - PTR_W'(call_nparams);
            fsize <= PTR_W'(call_nparams) + PTR_W'(call_nlocals);
            zcnt <= call_nlocals;
            if (call_nlocals != '0) begin st <= ST_ZFILL; op_rdy <= 1'b0; end
         end else if (ok && ret_en) begin
            base <= f_base;
            fsize <= f_size;
         end
      end
`ifdef WASM_OPSTK_HWM_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) max_top <= '0;
      else if (top_nx > max_top) max_top <= top_nx;
`endif
   wasm_frame_lifo #(.FDEPTH(FDEPTH), .DW(2*PTR_W)) u_frames (
      .clk(clk),
      .rst(rst),
      .push(ok && call_en),
      .pop(ok && ret_en),
      .din({base, fsize}),
      .dout(f_dout),
      .full(f_full),
      .empty(f_empty),
      .level(frame_level)
   );
endmodule

// File: tb/tb_wasm_operand_stack_v2.sv
// tb_wasm_operand_stack_v2: directed vectors with hand-computed expectations for the operand stack.
module tb_wasm_operand_stack_v2;
   import wasm_opstk_pkg::*;
   logic clk = 0, rst = 1, op_vld = 0, op_rdy;
   logic [3:0] pop_num = 0;
   logic push_en = 0, call_en = 0, ret_en = 0, ret_num = 0;
   logic [31:0] push_data = 0, local_data;
   logic [7:0] call_nparams = 0, call_nlocals = 0, local_idx = 0;
   logic [1:0] local_op = 0;
   logic [95:0] win_data;
   logic [6:0] top_ptr, frame_base;
   logic [4:0] frame_level;
   logic err_vld, err_sticky;
   logic [2:0] err_code;
`ifdef WASM_OPSTK_HWM_EN
   logic [6:0] max_top;
`endif
   int vecs = 0, errs = 0;
   int cnt;
   always #5 clk = ~clk;
   wasm_operand_stack_v2 dut (
      .clk(clk), .rst(rst), .op_vld(op_vld), .op_rdy(op_rdy), .pop_num(pop_num),
      .push_en(push_en), .push_data(push_data), .call_en(call_en), .call_nparams(call_nparams),
      .call_nlocals(call_nlocals), .ret_en(ret_en), .ret_num(ret_num), .local_op(local_op),
      .local_idx(local_idx), .win_data(win_data), .local_data(local_data), .top_ptr(top_ptr),
      .frame_base(frame_base), .frame_level(frame_level), .err_vld(err_vld),
      .err_code(err_code), .err_sticky(err_sticky)
`ifdef WASM_OPSTK_HWM_EN
      , .max_top(max_top)
`endif
   );
   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic issue(input logic [3:0] pn, input logic pe, input logic [31:0] d, input logic ce,
                        input logic [7:0] np, input logic [7:0] nl, input logic re, input logic rn,
                        input logic [1:0] lo, input logic [7:0] li);
      int n = 0;
      while (!op_rdy && n < 50) begin @(posedge clk); #1; n++; end
      if (n == 50) check("rdy_timeout", 0, 1);
      pop_num = pn; push_en = pe; push_data = d; call_en = ce; call_nparams = np;
      call_nlocals = nl; ret_en = re; ret_num = rn; local_op = lo; local_idx = li; op_vld = 1;
      @(posedge clk); #1;
      op_vld = 0; pop_num = 0; push_en = 0; push_data = 0; call_en = 0; call_nparams = 0;
      call_nlocals = 0; ret_en = 0; ret_num = 0; local_op = 0; local_idx = 0;
   endtask
   task automatic push(input logic [31:0] v);
      issue(0, 1, v, 0, 0, 0, 0, 0, LOP_NONE, 0);
   endtask
   task automatic reset_dut();
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 0;
      check("rst_rdy", op_rdy, 1);
      check("rst_top", top_ptr, 0);
      check("rst_level", frame_level, 0);
      check("rst_err", {err_vld, err_sticky, err_code}, 0);
      check("rst_win", win_data, 0);
      push(5); push(7); push(9);
      check("push3_top", top_ptr, 3);
      check("push3_win", win_data, {32'd5, 32'd7, 32'd9});
      issue(2, 1, 16, 0, 0, 0, 0, 0, LOP_NONE, 0);
      check("popush_top", top_ptr, 2);
      check("popush_win", win_data, {32'd0, 32'd5, 32'd16});
      reset_dut();
      push(1); push(2);
      issue(0, 0, 0, 1, 2, 3, 0, 0, LOP_NONE, 0);
      check("zf_rdy_low", op_rdy, 0);
      check("zf_top0", top_ptr, 2);
      cnt = 0;
      while (!op_rdy && cnt < 20) begin @(posedge clk); #1; cnt++; end
      check("zf_cycles", cnt, 3);
      check("call_top", top_ptr, 5);
      check("call_base", frame_base, 0);
      check("call_level", frame_level, 1);
      local_idx = 1; #1 check("loc1", local_data, 2);
      local_idx = 2; #1 check("loc2_zero", local_data, 0);
      local_idx = 4; #1 check("loc4_zero", local_data, 0);
      local_idx = 0;
      push(42);
      issue(0, 0, 0, 0, 0, 0, 0, 0, LOP_SET, 4);
      check("set_top", top_ptr, 5);
      issue(0, 0, 0, 0, 0, 0, 0, 0, LOP_GET, 4);
      check("get_top", top_ptr, 6);
      check("get_val", win_data[31:0], 42);
      issue(0, 0, 0, 0, 0, 0, 0, 0, LOP_GET, 5);
      check("range_vld", err_vld, 1);
      check("range_code", err_code, ERR_LOCAL_RANGE);
      check("range_top", top_ptr, 6);
      issue(0, 0, 0, 0, 0, 0, 0, 0, LOP_TEE, 0);
      check("tee_top", top_ptr, 6);
      check("tee_noerr", err_vld, 0);
      local_idx = 0; #1 check("tee_val", local_data, 42);
      push(99);
      issue(0, 0, 0, 0, 0, 0, 1, 1, LOP_NONE, 0);
      check("ret_top", top_ptr, 1);
      check("ret_win", win_data, {32'd0, 32'd0, 32'd99});
      check("ret_level", frame_level, 0);
      issue(0, 0, 0, 0, 0, 0, 1, 0, LOP_NONE, 0);
      check("unf_code", err_code, ERR_FRAME_UNF);
      check("unf_sticky", err_sticky, 1);
      issue(0, 0, 0, 0, 0, 0, 0, 0, LOP_GET, 0);
      check("outer_range", err_code, ERR_LOCAL_RANGE);
      issue(2, 0, 0, 0, 0, 0, 0, 0, LOP_NONE, 0);
      check("under_code", err_code, ERR_UNDERFLOW);
      check("under_top", top_ptr, 1);
      issue(0, 1, 1, 1, 0, 0, 0, 0, LOP_NONE, 0);
      check("illegal_code", err_code, ERR_ILLEGAL);
      check("illegal_level", frame_level, 0);
      reset_dut();
      for (int i = 0; i < 64; i++) push(100 + i);
      check("full_top", top_ptr, 64);
      check("full_win", win_data, {32'd161, 32'd162, 32'd163});
      push(555);
      check("over_code", err_code, ERR_OVERFLOW);
      check("over_top", top_ptr, 64);
      issue(1, 1, 77, 0, 0, 0, 0, 0, LOP_NONE, 0);
      check("full_swap", win_data[31:0], 77);
      check("full_swap_top", top_ptr, 64);
`ifdef WASM_OPSTK_HWM_EN
      check("hwm", max_top, 64);
`endif
      reset_dut();
      check("rst2_sticky", err_sticky, 0);
      for (int i = 0; i < 16; i++) issue(0, 0, 0, 1, 0, 0, 0, 0, LOP_NONE, 0);
      check("nest_level", frame_level, 16);
      check("nest_rdy", op_rdy, 1);
      check("nest_noerr", err_sticky, 0);
      issue(0, 0, 0, 1, 0, 0, 0, 0, LOP_NONE, 0);
      check("fovf_code", err_code, ERR_FRAME_OVF);
      check("fovf_level", frame_level, 16);
      issue(0, 0, 0, 0, 0, 0, 1, 0, LOP_NONE, 0);
      check("nest_ret", frame_level, 15);
      reset_dut();
      issue(0, 0, 0, 1, 0, 5, 0, 0, LOP_NONE, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_zf_top", top_ptr, 2);
      check("mid_zf_rdy", op_rdy, 0);
      #2 rst = 1;
      #1 check("arst_rdy", op_rdy, 1);
      check("arst_top", top_ptr, 0);
      check("arst_level", frame_level, 0);
      @(posedge clk); #1 rst = 0;
      push(3);
      check("post_rst_top", top_ptr, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
